// File: rtl/snn_pkg.sv
// Shared constants and saturating helpers for the spiking layer.
// Saturation width is passed at call time so one helper fits every register.
package snn_pkg;

  localparam int N_PRE_D      = 4;
  localparam int W_WIDTH_D    = 8;
  localparam int V_WIDTH_D    = 8;
  localparam int THRESH_D     = 200;
  localparam int LEAK_SHIFT_D = 3;
  localparam int REFRAC_D     = 2;
  localparam int T_WIDTH_D    = 4;
  localparam int T_WIN_D      = 8;
  localparam int A_PLUS_D     = 4;
  localparam int A_MINUS_D    = 2;
  localparam int W_INIT_D     = 64;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] m;
    logic [31:0] d;
    m = (33'd1 << w) - 33'd1;
    d = (a > b) ? a - b : 32'd0;
    return d & m[31:0];
  endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One plastic synapse: weight register, pre-spike timer and
// host-write > LTP > LTD update priority.
module stdp_synapse
  import snn_pkg::*;
#(
  parameter int W_WIDTH = W_WIDTH_D,
  parameter int T_WIDTH = T_WIDTH_D,
  parameter int T_WIN   = T_WIN_D,
  parameter int A_PLUS  = A_PLUS_D,
  parameter int A_MINUS = A_MINUS_D,
  parameter int W_INIT  = W_INIT_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               post_near,
  input  logic               learn_en,
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic [W_WIDTH-1:0] weight
);

  localparam logic [T_WIDTH-1:0] T_MAX = '1;

  logic [T_WIDTH-1:0] timer_q;
  logic [W_WIDTH-1:0] w_q;
  logic [W_WIDTH-1:0] w_nxt;
  logic               ltp;
  logic               ltd;

  assign ltp = learn_en && post_spike
            && (timer_q < T_WIDTH'(T_WIN));
  // A pre spike coinciding with the post spike is causal, never LTD.
  assign ltd = learn_en && pre_spike
            && post_near && !post_spike;

  always_comb begin
    w_nxt = w_q;
    if (wr_en) begin
      w_nxt = wr_data;
    end else if (ltp) begin
      w_nxt = W_WIDTH'(sat_add(32'(w_q),
        32'(A_PLUS), W_WIDTH));
    end else if (ltd) begin
      w_nxt = W_WIDTH'(sat_sub(32'(w_q),
        32'(A_MINUS), W_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= W_WIDTH'(W_INIT);
      timer_q <= T_MAX;
    end else begin
      w_q <= w_nxt;
      if (pre_spike) begin
        timer_q <= '0;
      end else if (timer_q != T_MAX) begin
        timer_q <= timer_q + T_WIDTH'(1);
      end
    end
  end

  assign weight = w_q;

endmodule

// File: rtl/stdp_layer.sv
// N-input LIF neuron with per-synapse pair-based STDP,
// refractory period and a host weight port.
module stdp_layer
  import snn_pkg::*;
#(
  parameter int N_PRE      = N_PRE_D,
  parameter int W_WIDTH    = W_WIDTH_D,
  parameter int V_WIDTH    = V_WIDTH_D,
  parameter int THRESH     = THRESH_D,
  parameter int LEAK_SHIFT = LEAK_SHIFT_D,
  parameter int REFRAC     = REFRAC_D,
  parameter int T_WIDTH    = T_WIDTH_D,
  parameter int T_WIN      = T_WIN_D,
  parameter int A_PLUS     = A_PLUS_D,
  parameter int A_MINUS    = A_MINUS_D,
  parameter int W_INIT     = W_INIT_D,
  localparam int A_W = (N_PRE > 1) ? $clog2(N_PRE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PRE-1:0]   pre_spike,
  input  logic               learn_en,
  input  logic               w_wr_en,
  input  logic [A_W-1:0]     w_addr,
  input  logic [W_WIDTH-1:0] w_wr_data,
  output logic [W_WIDTH-1:0] w_rd_data,
  output logic               post_spike,
  output logic [V_WIDTH-1:0] post_state
);

  localparam int S_W = V_WIDTH + W_WIDTH + A_W;
  localparam int R_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [T_WIDTH-1:0] T_MAX = '1;
  localparam logic [S_W-1:0] V_MAX =
    {{(S_W-V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}};

  logic [W_WIDTH-1:0] w_arr [N_PRE];
  logic [V_WIDTH-1:0] v_q;
  logic               spike_q;
  logic [R_W-1:0]     rc_q;
  logic [T_WIDTH-1:0] pt_q;
  logic [S_W-1:0]     sum;
  logic               post_near;

  assign post_near = pt_q < T_WIDTH'(T_WIN);

  for (genvar i = 0; i < N_PRE; i++) begin : g_syn
    stdp_synapse #(
      .W_WIDTH (W_WIDTH),
      .T_WIDTH (T_WIDTH),
      .T_WIN   (T_WIN),
      .A_PLUS  (A_PLUS),
      .A_MINUS (A_MINUS),
      .W_INIT  (W_INIT)
    ) u_syn (
      .clk        (clk),
      .rst        (rst),
      .pre_spike  (pre_spike[i]),
      .post_spike (spike_q),
      .post_near  (post_near),
      .learn_en   (learn_en),
      .wr_en      (w_wr_en && (w_addr == A_W'(i))),
      .wr_data    (w_wr_data),
      .weight     (w_arr[i])
    );
  end

  always_comb begin
    sum = S_W'(v_q) - S_W'(v_q >> LEAK_SHIFT);
    for (int i = 0; i < N_PRE; i++) begin
      if (pre_spike[i]) sum = sum + S_W'(w_arr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      spike_q <= 1'b0;
      rc_q    <= '0;
      pt_q    <= T_MAX;
    end else begin
      if (spike_q) begin
        pt_q <= '0;
      end else if (pt_q != T_MAX) begin
        pt_q <= pt_q + T_WIDTH'(1);
      end
      if (rc_q != '0) begin
        v_q     <= '0;
        spike_q <= 1'b0;
        rc_q    <= rc_q - R_W'(1);
      end else if (sum >= S_W'(THRESH)) begin
        v_q     <= '0;
        spike_q <= 1'b1;
        rc_q    <= R_W'(REFRAC);
      end else begin
        spike_q <= 1'b0;
        v_q <= (sum > V_MAX) ? '1
             : sum[V_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (int'(w_addr) < N_PRE) w_rd_data = w_arr[w_addr];
  end

  assign post_spike = spike_q;
  assign post_state = v_q;

endmodule
